// File: rtl/miss_pkg.sv
// Shared sizes and table-entry types for the per-tile miss scheduler.
package miss_pkg;
  localparam int unsigned NREQ = 36;
  localparam int unsigned NOUT = 8;
  localparam int unsigned TAGW = 3;
  localparam int unsigned AW   = 39;
  localparam int unsigned PW   = 40;
  localparam int unsigned IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {FREE, PEND, ISSUED, DONE} mstate_t;

  typedef struct packed {
    mstate_t         state;
    logic [AW-1:0]   addr;
    logic [NREQ-1:0] waiters;
    logic [PW-1:0]   phy;
  } miss_ent_t;
endpackage

// File: rtl/rr_arb.sv
// Rotating-priority one-hot arbiter; the pointer moves just past the winner on i_adv.
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] r_ptr;

  always_comb begin
    int unsigned j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = off + 32'(r_ptr);
      if (j >= N) j = j - N;
      if (!o_any && i_req[IW'(j)]) begin
        o_any            = 1'b1;
        o_idx            = IW'(j);
        o_gnt[IW'(j)]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (o_idx == IW'(N-1)) ? '0 : o_idx + 1'b1;
    end
  end
endmodule

// File: rtl/miss_sched.sv
// Per-tile miss scheduler: round-robin accept with line merging, in-order issue
// to memblk, and broadcast of each line's physical result to all waiting PHYs.
module miss_sched
  import miss_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               memstall,
  input  logic [NREQ-1:0]    req_en,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ack,
  output logic               mem_vld,
  output logic [AW-1:0]      mem_addr,
  output logic [TAGW-1:0]    mem_tag,
  input  logic               mem_rdy,
  input  logic               rsp_vld,
  input  logic [TAGW-1:0]    rsp_tag,
  input  logic [PW-1:0]      rsp_phy,
  output logic [NREQ-1:0]    done_mask,
  output logic [PW-1:0]      done_phy,
  output logic               full
);
  miss_ent_t       r_ent     [NOUT];
  miss_ent_t       w_ent_nxt [NOUT];
  logic [TAGW-1:0] r_fifo    [NOUT];
  logic [TAGW-1:0] r_rd, r_wr;
  logic [TAGW:0]   r_cnt;
  logic [NREQ-1:0] r_ack;
  logic            r_full;

  logic [AW-1:0]   w_req_addr [NREQ];
  logic [NREQ-1:0] w_req_m, w_gnt;
  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic [AW-1:0]   w_addr;
  logic            w_hit, w_free_any, w_cmp_any, w_free_nxt;
  logic [TAGW-1:0] w_hit_tag, w_free_tag, w_cmp_tag, w_head;
  logic            w_do_merge, w_do_alloc, w_adv;
  logic            w_issue_vld, w_fire, w_rsp_ok;

  // Last cycle's winner still holds req_en while seeing its ack; keep it out.
  assign w_req_m = req_en & ~r_ack;

  rr_arb #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req_m),
    .i_adv (w_adv),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) w_req_addr[i] = req_addr[i*AW +: AW];
  end
  assign w_addr = w_req_addr[w_idx];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_tag  = '0;
    w_free_any = 1'b0;
    w_free_tag = '0;
    w_cmp_any  = 1'b0;
    w_cmp_tag  = '0;
    for (int unsigned t = 0; t < NOUT; t++) begin
      if (!w_hit && (r_ent[t].state == PEND || r_ent[t].state == ISSUED) &&
          r_ent[t].addr == w_addr) begin
        w_hit     = 1'b1;
        w_hit_tag = TAGW'(t);
      end
      if (!w_free_any && r_ent[t].state == FREE) begin
        w_free_any = 1'b1;
        w_free_tag = TAGW'(t);
      end
      if (!w_cmp_any && r_ent[t].state == DONE) begin
        w_cmp_any = 1'b1;
        w_cmp_tag = TAGW'(t);
      end
    end
  end

  assign w_do_merge  = w_any & w_hit;
  assign w_do_alloc  = w_any & ~w_hit & w_free_any;
  assign w_adv       = w_do_merge | w_do_alloc;
  assign w_head      = r_fifo[r_rd];
  assign w_issue_vld = (r_cnt != '0) & ~memstall;
  assign w_fire      = w_issue_vld & mem_rdy;
  assign w_rsp_ok    = rsp_vld & (r_ent[rsp_tag].state == ISSUED);

  // Each event targets an entry in a different state, so the updates never collide;
  // a merge only ORs waiters and may share an entry with issue or response.
  always_comb begin
    for (int unsigned t = 0; t < NOUT; t++) w_ent_nxt[t] = r_ent[t];
    if (w_cmp_any) begin
      w_ent_nxt[w_cmp_tag].state   = FREE;
      w_ent_nxt[w_cmp_tag].waiters = '0;
    end
    if (w_rsp_ok) begin
      w_ent_nxt[rsp_tag].state = DONE;
      w_ent_nxt[rsp_tag].phy   = rsp_phy;
    end
    if (w_fire) w_ent_nxt[w_head].state = ISSUED;
    if (w_do_merge) w_ent_nxt[w_hit_tag].waiters = w_ent_nxt[w_hit_tag].waiters | w_gnt;
    if (w_do_alloc) begin
      w_ent_nxt[w_free_tag].state   = PEND;
      w_ent_nxt[w_free_tag].addr    = w_addr;
      w_ent_nxt[w_free_tag].waiters = w_gnt;
      w_ent_nxt[w_free_tag].phy     = '0;
    end
  end

  always_comb begin
    w_free_nxt = 1'b0;
    for (int unsigned t = 0; t < NOUT; t++) begin
      if (w_ent_nxt[t].state == FREE) w_free_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NOUT; t++) begin
        r_ent[t]  <= '0;
        r_fifo[t] <= '0;
      end
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_ack  <= '0;
      r_full <= 1'b0;
    end else begin
      for (int unsigned t = 0; t < NOUT; t++) r_ent[t] <= w_ent_nxt[t];
      if (w_do_alloc) begin
        r_fifo[r_wr] <= w_free_tag;
        r_wr         <= r_wr + 1'b1;
      end
      if (w_fire) r_rd <= r_rd + 1'b1;
      r_cnt  <= r_cnt + {{TAGW{1'b0}}, w_do_alloc} - {{TAGW{1'b0}}, w_fire};
      r_ack  <= w_adv ? w_gnt : '0;
      r_full <= ~w_free_nxt;
    end
  end

  assign req_ack   = r_ack;
  assign mem_vld   = w_issue_vld;
  assign mem_addr  = w_issue_vld ? r_ent[w_head].addr : '0;
  assign mem_tag   = w_issue_vld ? w_head : '0;
  assign done_mask = w_cmp_any ? r_ent[w_cmp_tag].waiters : '0;
  assign done_phy  = w_cmp_any ? r_ent[w_cmp_tag].phy : '0;
  assign full      = r_full;

  a_rsp_tag_issued: assert property (@(posedge clk) disable iff (!rst)
    rsp_vld |-> (r_ent[rsp_tag].state == ISSUED))
    else $warning("miss_sched: rsp_vld for tag %0d that is not ISSUED, ignored", rsp_tag);
endmodule

// File: tb/tb_miss_sched.sv
// Scoreboard bench for miss_sched: expected acks/completions are queued with the stimulus
// and popped as the DUT produces them; PHYs drop req_en the cycle after their ack.
module tb_miss_sched;
  import miss_pkg::*;

  logic               clk;
  logic               rst;
  logic               memstall;
  logic [NREQ-1:0]    req_en;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ack;
  logic               mem_vld;
  logic [AW-1:0]      mem_addr;
  logic [TAGW-1:0]    mem_tag;
  logic               mem_rdy;
  logic               rsp_vld;
  logic [TAGW-1:0]    rsp_tag;
  logic [PW-1:0]      rsp_phy;
  logic [NREQ-1:0]    done_mask;
  logic [PW-1:0]      done_phy;
  logic               full;

  typedef struct packed {
    logic [NREQ-1:0] m;
    logic [PW-1:0]   p;
  } dexp_t;

  logic [NREQ-1:0] ackq [$];
  dexp_t           doneq [$];
  int              errors;
  int              checks;
  int              n_issue;

  logic [NREQ-1:0] o_ack;
  logic            o_vld;
  logic [AW-1:0]   o_addr;
  logic [TAGW-1:0] o_tag;
  logic [NREQ-1:0] o_dm;
  logic [PW-1:0]   o_dp;
  logic            o_full;

  miss_sched dut (
    .clk       (clk),
    .rst       (rst),
    .memstall  (memstall),
    .req_en    (req_en),
    .req_addr  (req_addr),
    .req_ack   (req_ack),
    .mem_vld   (mem_vld),
    .mem_addr  (mem_addr),
    .mem_tag   (mem_tag),
    .mem_rdy   (mem_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_tag   (rsp_tag),
    .rsp_phy   (rsp_phy),
    .done_mask (done_mask),
    .done_phy  (done_phy),
    .full      (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NREQ-1:0] oh(input int unsigned i);
    oh = {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
    req_en = req_en | oh(i);
  endtask

  // One clock cycle: sample mid-cycle, score acks/completions, then drop acked requests.
  task automatic tick();
    logic [NREQ-1:0] seen;
    logic [NREQ-1:0] ea;
    dexp_t           ed;
    @(negedge clk);
    o_ack  = req_ack;
    o_vld  = mem_vld;
    o_addr = mem_addr;
    o_tag  = mem_tag;
    o_dm   = done_mask;
    o_dp   = done_phy;
    o_full = full;
    if (mem_vld && mem_rdy) n_issue++;
    if (req_ack !== '0) begin
      checks++;
      if (ackq.size() == 0) begin
        errors++;
        $display("FAIL ack_sb: req_ack=%h with no ack expected", req_ack);
      end else begin
        ea = ackq.pop_front();
        if (req_ack !== ea) begin
          errors++;
          $display("FAIL ack_sb: req_ack=%h expected %h", req_ack, ea);
        end
      end
    end
    if (done_mask !== '0) begin
      checks++;
      if (doneq.size() == 0) begin
        errors++;
        $display("FAIL done_sb: done_mask=%h with no completion expected", done_mask);
      end else begin
        ed = doneq.pop_front();
        if (done_mask !== ed.m || done_phy !== ed.p) begin
          errors++;
          $display("FAIL done_sb: mask=%h phy=%h expected mask=%h phy=%h",
                   done_mask, done_phy, ed.m, ed.p);
        end
      end
    end
    seen = req_ack;
    @(posedge clk);
    #1;
    req_en = req_en & ~seen;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks += 4;
    if (o_ack !== '0) begin errors++; $display("FAIL rst_ack: req_ack=%h expected 0", o_ack); end
    if (o_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: mem_vld=%b expected 0", o_vld); end
    if (o_dm !== '0) begin errors++; $display("FAIL rst_done: done_mask=%h expected 0", o_dm); end
    if (o_full !== 1'b0) begin errors++; $display("FAIL rst_full: full=%b expected 0", o_full); end
    rst = 1'b1;
    tick();
    checks += 4;
    if (o_vld !== 1'b0) begin errors++; $display("FAIL rel_vld: mem_vld=%b expected 0", o_vld); end
    if (o_tag !== '0) begin errors++; $display("FAIL rel_tag: mem_tag=%h expected 0", o_tag); end
    if (o_dp !== '0) begin errors++; $display("FAIL rel_phy: done_phy=%h expected 0", o_dp); end
    if (o_full !== 1'b0) begin errors++; $display("FAIL rel_full: full=%b expected 0", o_full); end
  endtask

  task automatic test_single();
    mem_rdy = 1'b1;
    set_req(5, 39'h100);
    ackq.push_back(oh(5));
    doneq.push_back('{m: oh(5), p: 40'hAB00});
    tick();  // cycle 0
    checks++;
    if (o_vld !== 1'b0) begin errors++; $display("FAIL t1_vld_c0: mem_vld=%b expected 0", o_vld); end
    tick();  // cycle 1
    checks += 4;
    if (o_ack !== oh(5)) begin errors++; $display("FAIL t1_ack_c1: req_ack=%h expected %h", o_ack, oh(5)); end
    if (o_vld !== 1'b1) begin errors++; $display("FAIL t1_vld_c1: mem_vld=%b expected 1", o_vld); end
    if (o_tag !== 3'd0) begin errors++; $display("FAIL t1_tag_c1: mem_tag=%0d expected 0", o_tag); end
    if (o_addr !== 39'h100) begin errors++; $display("FAIL t1_addr_c1: mem_addr=%h expected 100", o_addr); end
    tick();  // cycle 2
    checks++;
    if (o_vld !== 1'b0) begin errors++; $display("FAIL t1_vld_c2: mem_vld=%b expected 0", o_vld); end
    tick();  // cycle 3
    rsp_vld = 1'b1;
    rsp_tag = 3'd0;
    rsp_phy = 40'hAB00;
    tick();  // cycle 4
    rsp_vld = 1'b0;
    tick();  // cycle 5
    checks += 2;
    if (o_dm !== oh(5)) begin errors++; $display("FAIL t1_done_c5: done_mask=%h expected %h", o_dm, oh(5)); end
    if (o_dp !== 40'hAB00) begin errors++; $display("FAIL t1_phy_c5: done_phy=%h expected ab00", o_dp); end
    tick();  // cycle 6
    checks++;
    if (o_dm !== '0) begin errors++; $display("FAIL t1_done_c6: done_mask=%h expected 0", o_dm); end
  endtask

  task automatic test_merge();
    n_issue = 0;
    mem_rdy = 1'b1;
    set_req(3, 39'h200);
    ackq.push_back(oh(3));
    ackq.push_back(oh(7));
    doneq.push_back('{m: oh(3) | oh(7), p: 40'hCD00});
    tick();
    set_req(7, 39'h200);
    tick();
    checks++;
    if (o_tag !== 3'd0) begin errors++; $display("FAIL t2_tag: mem_tag=%0d expected 0", o_tag); end
    repeat (4) tick();
    checks++;
    if (n_issue != 1) begin errors++; $display("FAIL t2_issues: issues=%0d expected 1", n_issue); end
    rsp_vld = 1'b1;
    rsp_tag = 3'd0;
    rsp_phy = 40'hCD00;
    tick();
    rsp_vld = 1'b0;
    for (int k = 0; k < 10 && (ackq.size() != 0 || doneq.size() != 0); k++) tick();
    checks++;
    if (ackq.size() != 0 || doneq.size() != 0) begin
      errors++;
      $display("FAIL t2_drain: acks left=%0d dones left=%0d expected 0", ackq.size(), doneq.size());
    end
  endtask

  task automatic test_full();
    apply_reset();
    n_issue = 0;
    mem_rdy = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, AW'(i) + 39'h1000);
    for (int unsigned i = 0; i < NOUT; i++) ackq.push_back(oh(i));
    repeat (16) tick();
    checks += 4;
    if (ackq.size() != 0) begin errors++; $display("FAIL t3_acks: acks left=%0d expected 0", ackq.size()); end
    if (o_full !== 1'b1) begin errors++; $display("FAIL t3_full: full=%b expected 1", o_full); end
    if (req_en[8] !== 1'b1) begin errors++; $display("FAIL t3_hold8: phy8 acked before completion"); end
    if (n_issue != 8) begin errors++; $display("FAIL t3_issues: issues=%0d expected 8", n_issue); end
    rsp_vld = 1'b1;
    rsp_tag = 3'd3;
    rsp_phy = 40'h3300;
    doneq.push_back('{m: oh(3), p: 40'h3300});
    ackq.push_back(oh(8));
    tick();
    rsp_vld = 1'b0;
    for (int k = 0; k < 10 && (ackq.size() != 0 || doneq.size() != 0); k++) tick();
    checks++;
    if (ackq.size() != 0 || doneq.size() != 0) begin
      errors++;
      $display("FAIL t3_drain: acks left=%0d dones left=%0d expected 0", ackq.size(), doneq.size());
    end
    repeat (2) tick();
    checks += 2;
    if (req_en[8] !== 1'b0) begin errors++; $display("FAIL t3_ack8: phy8 still unacked"); end
    if (o_full !== 1'b1) begin errors++; $display("FAIL t3_refull: full=%b expected 1", o_full); end
    req_en = '0;
    apply_reset();
  endtask

  task automatic test_wrap();
    apply_reset();
    mem_rdy = 1'b1;
    set_req(34, 39'h3400);
    ackq.push_back(oh(34));
    for (int k = 0; k < 10 && ackq.size() != 0; k++) tick();
    set_req(35, 39'h3500);
    set_req(0, 39'h0A00);
    ackq.push_back(oh(35));
    ackq.push_back(oh(0));
    for (int k = 0; k < 10 && ackq.size() != 0; k++) tick();
    checks++;
    if (ackq.size() != 0) begin errors++; $display("FAIL t4_drain: acks left=%0d expected 0", ackq.size()); end
    tick();
    checks++;
    if (req_en !== '0) begin errors++; $display("FAIL t4_reqs: req_en=%h expected 0", req_en); end
  endtask

  task automatic test_memstall();
    apply_reset();
    memstall = 1'b1;
    mem_rdy  = 1'b1;
    set_req(1, 39'h111);
    set_req(2, 39'h222);
    ackq.push_back(oh(1));
    ackq.push_back(oh(2));
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (o_vld !== 1'b0) begin errors++; $display("FAIL t5_stall%0d: mem_vld=%b expected 0", k, o_vld); end
    end
    memstall = 1'b0;
    tick();
    checks += 3;
    if (o_vld !== 1'b1) begin errors++; $display("FAIL t5_vld0: mem_vld=%b expected 1", o_vld); end
    if (o_tag !== 3'd0) begin errors++; $display("FAIL t5_tag0: mem_tag=%0d expected 0", o_tag); end
    if (o_addr !== 39'h111) begin errors++; $display("FAIL t5_addr0: mem_addr=%h expected 111", o_addr); end
    tick();
    checks += 3;
    if (o_vld !== 1'b1) begin errors++; $display("FAIL t5_vld1: mem_vld=%b expected 1", o_vld); end
    if (o_tag !== 3'd1) begin errors++; $display("FAIL t5_tag1: mem_tag=%0d expected 1", o_tag); end
    if (o_addr !== 39'h222) begin errors++; $display("FAIL t5_addr1: mem_addr=%h expected 222", o_addr); end
    tick();
    checks += 2;
    if (o_vld !== 1'b0) begin errors++; $display("FAIL t5_vld2: mem_vld=%b expected 0", o_vld); end
    if (ackq.size() != 0) begin errors++; $display("FAIL t5_acks: acks left=%0d expected 0", ackq.size()); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    n_issue = 0;
    mem_rdy = 1'b1;
    for (int unsigned i = 10; i < 14; i++) begin
      set_req(i, AW'(i) + 39'h5000);
      ackq.push_back(oh(i));
    end
    for (int k = 0; k < 12 && ackq.size() != 0; k++) tick();
    repeat (3) tick();
    checks += 2;
    if (n_issue != 4) begin errors++; $display("FAIL t6_issued: issues=%0d expected 4", n_issue); end
    if (ackq.size() != 0) begin errors++; $display("FAIL t6_acks: acks left=%0d expected 0", ackq.size()); end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int unsigned t = 0; t < 5; t++) begin
      rsp_vld = (t < 4);
      rsp_tag = TAGW'(t);
      rsp_phy = 40'h7700 + PW'(t);
      tick();
      checks++;
      if (o_dm !== '0) begin errors++; $display("FAIL t6_done%0d: done_mask=%h expected 0", t, o_dm); end
    end
    rsp_vld = 1'b0;
    tick();
    checks += 4;
    if (o_dm !== '0) begin errors++; $display("FAIL t6_done_end: done_mask=%h expected 0", o_dm); end
    if (o_full !== 1'b0) begin errors++; $display("FAIL t6_full: full=%b expected 0", o_full); end
    if (o_vld !== 1'b0) begin errors++; $display("FAIL t6_vld: mem_vld=%b expected 0", o_vld); end
    if (o_ack !== '0) begin errors++; $display("FAIL t6_ack: req_ack=%h expected 0", o_ack); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    n_issue  = 0;
    rst      = 1'b0;
    memstall = 1'b0;
    req_en   = '0;
    req_addr = '0;
    mem_rdy  = 1'b0;
    rsp_vld  = 1'b0;
    rsp_tag  = '0;
    rsp_phy  = '0;
    test_reset();
    test_single();
    test_merge();
    test_full();
    test_wrap();
    test_memstall();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
